// File: rtl/config_stream_loader.sv
// Purpose: assembles 8-byte host records (addr LSB-first, then data LSB-first) into config bus writes.
// Latency: record on the bus the cycle after its last byte is accepted, held HOLD_CYCLES cycles.
// Backpressure: in_ready drops for the whole write hold and permanently once the terminator is seen.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   in_data/in_valid/in_ready - host byte stream (valid/ready)
//   config_addr/config_data   - registered config bus driven to all tiles
//   busy                   - record partially assembled or write in progress
//   config_done            - terminator record seen; sticky until reset
//   write_count            - writes issued, saturating
module config_stream_loader #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        config_done,
    output logic [15:0] write_count
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  byte_idx;
    // Bytes shift in from the top, so after seven accepts byte 0 sits in [7:0]
    // and byte 6 in [55:48]; byte 7 is taken straight from in_data.
    logic [55:0] rec_sh;
    logic [3:0]  hold_cnt;

    logic        accept;
    logic        last_byte;
    logic        is_end;
    logic        hold_last;

    // Gated by reset so the host never sees a ready in the reset cycle itself.
    assign in_ready  = (state == LOAD) && !reset;
    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (byte_idx == 3'd7);
    assign is_end    = (rec_sh[31:0] == END_ADDR);
    assign hold_last = (hold_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        config_done = 1'b0;
        case (state)
            LOAD: begin
                busy = (byte_idx != 3'd0);
                if (last_byte) begin
                    state_nxt = is_end ? DONE : WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (hold_last) begin
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                config_done = 1'b1;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx    <= 3'd0;
            rec_sh      <= 56'd0;
            hold_cnt    <= 4'd0;
            config_addr <= IDLE_ADDR;
            config_data <= 32'd0;
            write_count <= 16'd0;
        end else begin
            if (accept) begin
                byte_idx <= byte_idx + 3'd1;
                rec_sh   <= {in_data, rec_sh[55:8]};
            end

            // The bus is only touched here and at the end of the hold, so a
            // partially assembled address is never visible to the tiles.
            if (last_byte && !is_end) begin
                config_addr <= rec_sh[31:0];
                config_data <= {in_data, rec_sh[55:32]};
                hold_cnt    <= 4'(HOLD_CYCLES - 1);
            end

            if (state == WRITE) begin
                if (hold_last) begin
                    config_addr <= IDLE_ADDR;
                    config_data <= 32'd0;
                    if (write_count != 16'hFFFF) begin
                        write_count <= write_count + 16'd1;
                    end
                end else begin
                    hold_cnt <= hold_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_config_stream_loader.sv
// Purpose: self-checking bench for config_stream_loader, HOLD_CYCLES=1 and HOLD_CYCLES=3 instances.
// Latency: checks record-on-bus timing, hold length and write spacing against a transaction model.
// Backpressure: exercises in_valid gaps, back-to-back records, terminator and resets.
module tb_config_stream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with HOLD_CYCLES=1
    logic        reset1, in_valid1, in_ready1, busy1, done1;
    logic [7:0]  in_data1;
    logic [31:0] addr1, data1;
    logic [15:0] cnt1;
    // Instance with HOLD_CYCLES=3
    logic        reset3, in_valid3, in_ready3, busy3, done3;
    logic [7:0]  in_data3;
    logic [31:0] addr3, data3;
    logic [15:0] cnt3;

    config_stream_loader #(.HOLD_CYCLES(1)) u1 (
        .clk(clk), .reset(reset1), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .config_addr(addr1), .config_data(data1),
        .busy(busy1), .config_done(done1), .write_count(cnt1)
    );

    config_stream_loader #(.HOLD_CYCLES(3)) u3 (
        .clk(clk), .reset(reset3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .config_addr(addr3), .config_data(data3),
        .busy(busy3), .config_done(done3), .write_count(cnt3)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_cnt1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: collapses consecutive non-idle cycles into one write transaction.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          start;
        int          len;
    } wr_t;

    wr_t mon1[$];
    wr_t mon3[$];
    bit  act1 = 1'b0;
    bit  act3 = 1'b0;
    int  low1 = 0;

    always @(negedge clk) begin
        if (addr1 !== 32'h0 || data1 !== 32'h0) begin
            if (act1 && mon1.size() > 0) mon1[$].len++;
            else mon1.push_back('{addr1, data1, cyc, 1});
            act1 = 1'b1;
        end else begin
            act1 = 1'b0;
        end
        if (addr3 !== 32'h0 || data3 !== 32'h0) begin
            if (act3 && mon3.size() > 0) mon3[$].len++;
            else mon3.push_back('{addr3, data3, cyc, 1});
            act3 = 1'b1;
        end else begin
            act3 = 1'b0;
        end
        if (in_ready1 === 1'b0 && reset1 === 1'b0) low1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel);
        if (sel) in_valid3 = 1'b0;
        else     in_valid1 = 1'b0;
    endtask

    // Offers one byte after 'gap' invalid cycles and returns just after the accepting edge.
    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        bit ok;
        int budget;
        for (int g = 0; g < gap; g++) begin
            if (sel) begin in_valid3 = 1'b0; in_data3 = 8'($urandom); end
            else     begin in_valid1 = 1'b0; in_data1 = 8'($urandom); end
            tick();
        end
        if (sel) begin in_data3 = b; in_valid3 = 1'b1; end
        else     begin in_data1 = b; in_valid1 = 1'b1; end
        ok = 1'b0;
        budget = 0;
        while (!ok && budget < 64) begin
            @(negedge clk);
            ok = sel ? in_ready3 : in_ready1;
            tick();
            budget++;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL accept_timeout: byte %h never accepted, in_ready got 0 required 1", b);
        end
    endtask

    // Record packing for the model: bits [31:0] = address, [63:32] = data; byte i = bits [8i+7:8i].
    task automatic send_rec(input bit sel, input logic [63:0] r, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            send_byte(sel, r[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    function automatic logic [63:0] rand_rec();
        logic [31:0] a;
        a = {16'($urandom_range(1, 65534)), 16'($urandom)};
        return {32'($urandom), a};
    endfunction

    task automatic test_reset();
        reset1 = 1'b1; reset3 = 1'b1;
        in_valid1 = 1'b0; in_valid3 = 1'b0; in_data1 = 8'h0; in_data3 = 8'h0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++; if (in_ready1 !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready1); end
        n_checks++; if (addr1 !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h required 00000000", addr1); end
        n_checks++; if (data1 !== 32'h0) begin n_errors++; $display("FAIL rst_data: got %h required 00000000", data1); end
        n_checks++; if (busy1 !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b required 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b required 0", done1); end
        n_checks++; if (cnt1 !== 16'h0) begin n_errors++; $display("FAIL rst_count: got %0d required 0", cnt1); end
        n_checks++; if (in_ready3 !== 1'b0 || addr3 !== 32'h0) begin n_errors++; $display("FAIL rst_u3: got ready %b addr %h required 0 00000000", in_ready3, addr3); end
        tick();
        reset1 = 1'b0; reset3 = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready1 !== 1'b1) begin n_errors++; $display("FAIL rst_release_ready: got %b required 1", in_ready1); end
        n_checks++; if (in_ready3 !== 1'b1) begin n_errors++; $display("FAIL rst_release_ready3: got %b required 1", in_ready3); end
        tick();
        exp_cnt1 = 0;
    endtask

    task automatic test_single();
        logic [7:0] seq [8];
        seq = '{8'h04, 8'h00, 8'h07, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) send_byte(1'b0, seq[i], 0);
        idle(1'b0);
        @(negedge clk);
        n_checks++; if (addr1 !== 32'h0007_0004) begin n_errors++; $display("FAIL single_addr: got %h required 00070004", addr1); end
        n_checks++; if (data1 !== 32'h0000_000D) begin n_errors++; $display("FAIL single_data: got %h required 0000000d", data1); end
        n_checks++; if (in_ready1 !== 1'b0 || busy1 !== 1'b1) begin n_errors++; $display("FAIL single_hold_flags: got ready %b busy %b required 0 1", in_ready1, busy1); end
        tick();
        @(negedge clk);
        exp_cnt1++;
        n_checks++; if (addr1 !== 32'h0 || data1 !== 32'h0) begin n_errors++; $display("FAIL single_idle: got %h/%h required 0/0", addr1, data1); end
        n_checks++; if (cnt1 !== 16'(exp_cnt1)) begin n_errors++; $display("FAIL single_count: got %0d required %0d", cnt1, exp_cnt1); end
        n_checks++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin n_errors++; $display("FAIL single_ready_back: got ready %b busy %b required 1 0", in_ready1, busy1); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] r0, r1;
        r0 = rand_rec();
        r1 = rand_rec();
        mon1.delete();
        low1 = 0;
        send_rec(1'b0, r0, 0);
        send_rec(1'b0, r1, 0);
        idle(1'b0);
        repeat (3) tick();
        exp_cnt1 += 2;
        n_checks++; if (mon1.size() != 2) begin n_errors++; $display("FAIL b2b_nwrites: got %0d required 2", mon1.size()); end
        if (mon1.size() == 2) begin
            n_checks++; if (mon1[0].a !== r0[31:0] || mon1[0].d !== r0[63:32]) begin n_errors++; $display("FAIL b2b_w0: got %h/%h required %h/%h", mon1[0].a, mon1[0].d, r0[31:0], r0[63:32]); end
            n_checks++; if (mon1[1].a !== r1[31:0] || mon1[1].d !== r1[63:32]) begin n_errors++; $display("FAIL b2b_w1: got %h/%h required %h/%h", mon1[1].a, mon1[1].d, r1[31:0], r1[63:32]); end
            n_checks++; if (mon1[0].len != 1 || mon1[1].len != 1) begin n_errors++; $display("FAIL b2b_len: got %0d,%0d required 1,1", mon1[0].len, mon1[1].len); end
            n_checks++; if (mon1[1].start - mon1[0].start != 9) begin n_errors++; $display("FAIL b2b_spacing: got %0d required 9", mon1[1].start - mon1[0].start); end
        end
        n_checks++; if (low1 != 2) begin n_errors++; $display("FAIL b2b_ready_low: got %0d cycles required 2", low1); end
        n_checks++; if (cnt1 !== 16'(exp_cnt1)) begin n_errors++; $display("FAIL b2b_count: got %0d required %0d", cnt1, exp_cnt1); end
    endtask

    task automatic test_gaps();
        logic [63:0] r;
        for (int k = 0; k < 12; k++) begin
            r = rand_rec();
            mon1.delete();
            for (int i = 0; i < 7; i++) send_byte(1'b0, r[i*8 +: 8], int'($urandom_range(0, 3)));
            n_checks++; if (mon1.size() != 0 || addr1 !== 32'h0) begin n_errors++; $display("FAIL gap_assembly_idle: got %0d writes addr %h required 0 00000000", mon1.size(), addr1); end
            send_byte(1'b0, r[63:56], int'($urandom_range(0, 3)));
            idle(1'b0);
            repeat (2) tick();
            exp_cnt1++;
            n_checks++; if (mon1.size() != 1) begin n_errors++; $display("FAIL gap_nwrites: got %0d required 1", mon1.size()); end
            else if (mon1[0].a !== r[31:0] || mon1[0].d !== r[63:32] || mon1[0].len != 1) begin
                n_errors++;
                $display("FAIL gap_write: got %h/%h len %0d required %h/%h len 1", mon1[0].a, mon1[0].d, mon1[0].len, r[31:0], r[63:32]);
            end
        end
        n_checks++; if (cnt1 !== 16'(exp_cnt1)) begin n_errors++; $display("FAIL gap_count: got %0d required %0d", cnt1, exp_cnt1); end
    endtask

    task automatic test_terminator();
        mon1.delete();
        send_rec(1'b0, 64'h0000_0000_FFFF_FFFF, 0);
        @(negedge clk);
        n_checks++; if (done1 !== 1'b1) begin n_errors++; $display("FAIL term_done: got %b required 1", done1); end
        n_checks++; if (in_ready1 !== 1'b0 || busy1 !== 1'b0) begin n_errors++; $display("FAIL term_flags: got ready %b busy %b required 0 0", in_ready1, busy1); end
        for (int i = 0; i < 20; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1 = 8'($urandom);
        end
        idle(1'b0);
        repeat (2) tick();
        n_checks++; if (mon1.size() != 0) begin n_errors++; $display("FAIL term_no_write: got %0d writes required 0", mon1.size()); end
        n_checks++; if (cnt1 !== 16'(exp_cnt1)) begin n_errors++; $display("FAIL term_count: got %0d required %0d", cnt1, exp_cnt1); end
        n_checks++; if (done1 !== 1'b1 || in_ready1 !== 1'b0) begin n_errors++; $display("FAIL term_sticky: got done %b ready %b required 1 0", done1, in_ready1); end
    endtask

    task automatic test_reset_midrecord();
        logic [63:0] ra, rb;
        reset1 = 1'b1; tick(); reset1 = 1'b0; tick();
        exp_cnt1 = 0;
        n_checks++; if (done1 !== 1'b0 || cnt1 !== 16'h0) begin n_errors++; $display("FAIL mid_rst_clear: got done %b count %0d required 0 0", done1, cnt1); end
        ra = rand_rec();
        rb = rand_rec();
        for (int i = 0; i < 5; i++) send_byte(1'b0, ra[i*8 +: 8], 0);
        idle(1'b0);
        reset1 = 1'b1; tick(); reset1 = 1'b0; tick();
        n_checks++; if (busy1 !== 1'b0) begin n_errors++; $display("FAIL mid_rst_busy: got %b required 0", busy1); end
        mon1.delete();
        send_rec(1'b0, rb, 2);
        idle(1'b0);
        repeat (3) tick();
        exp_cnt1++;
        n_checks++; if (mon1.size() != 1) begin n_errors++; $display("FAIL mid_rst_nwrites: got %0d required 1", mon1.size()); end
        else if (mon1[0].a !== rb[31:0] || mon1[0].d !== rb[63:32]) begin
            n_errors++;
            $display("FAIL mid_rst_write: got %h/%h required %h/%h", mon1[0].a, mon1[0].d, rb[31:0], rb[63:32]);
        end
        n_checks++; if (cnt1 !== 16'(exp_cnt1)) begin n_errors++; $display("FAIL mid_rst_count: got %0d required %0d", cnt1, exp_cnt1); end
    endtask

    task automatic test_hold3();
        logic [63:0] r, r2;
        r = rand_rec();
        r2 = rand_rec();
        mon3.delete();
        send_rec(1'b1, r, 1);
        idle(1'b1);
        repeat (5) tick();
        n_checks++; if (mon3.size() != 1) begin n_errors++; $display("FAIL h3_nwrites: got %0d required 1", mon3.size()); end
        else if (mon3[0].a !== r[31:0] || mon3[0].d !== r[63:32] || mon3[0].len != 3) begin
            n_errors++;
            $display("FAIL h3_write: got %h/%h len %0d required %h/%h len 3", mon3[0].a, mon3[0].d, mon3[0].len, r[31:0], r[63:32]);
        end
        n_checks++; if (cnt3 !== 16'd1) begin n_errors++; $display("FAIL h3_count: got %0d required 1", cnt3); end
        send_rec(1'b1, r2, 0);
        idle(1'b1);
        tick();
        @(negedge clk);
        n_checks++; if (addr3 !== r2[31:0]) begin n_errors++; $display("FAIL h3_second_hold: got %h required %h", addr3, r2[31:0]); end
        reset3 = 1'b1;
        tick();
        n_checks++; if (addr3 !== 32'h0 || data3 !== 32'h0) begin n_errors++; $display("FAIL h3_rst_idle: got %h/%h required 0/0", addr3, data3); end
        n_checks++; if (cnt3 !== 16'd0 || busy3 !== 1'b0 || in_ready3 !== 1'b0) begin n_errors++; $display("FAIL h3_rst_state: got count %0d busy %b ready %b required 0 0 0", cnt3, busy3, in_ready3); end
        reset3 = 1'b0;
        repeat (4) tick();
        n_checks++; if (cnt3 !== 16'd0 || addr3 !== 32'h0 || in_ready3 !== 1'b1) begin n_errors++; $display("FAIL h3_after_rst: got count %0d addr %h ready %b required 0 00000000 1", cnt3, addr3, in_ready3); end
    endtask

    initial begin
        reset1 = 1'b1; reset3 = 1'b1;
        in_valid1 = 1'b0; in_valid3 = 1'b0;
        in_data1 = 8'h0; in_data3 = 8'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gaps();
        test_terminator();
        test_reset_midrecord();
        test_hold3();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
